video_stream_gen: RTL

// - Source-side video timing + test-pattern generator: drives the video_vs/video_de/video_data[7:0] stream that

---
 rtl/video_stream_gen_pkg.sv | 19 +
 rtl/video_timing_core.sv | 52 +++++
 rtl/video_stream_gen.sv | 136 +++++++++++++
 3 files changed

// File: rtl/video_stream_gen_pkg.sv
// rtl/video_stream_gen_pkg.sv - shared counter width, pattern codes and FSM states for the video source
package video_stream_gen_pkg;

  localparam int CNT_W = 12;

  localparam logic [2:0] PAT_HRAMP   = 3'd0;
  localparam logic [2:0] PAT_VRAMP   = 3'd1;
  localparam logic [2:0] PAT_CHECKER = 3'd2;
  localparam logic [2:0] PAT_CONST   = 3'd3;
  localparam logic [2:0] PAT_MOVING  = 3'd4;
  localparam logic [2:0] PAT_DIAG    = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

endpackage

// File: rtl/video_timing_core.sv
// rtl/video_timing_core.sv - h/v raster counters with load/run control and active/vs/boundary flags
module video_timing_core
  import video_stream_gen_pkg::*;
#(
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080,
  parameter int H_BLANK    = 280,
  parameter int V_BLANK    = 45,
  parameter int VS_LINES   = 5
) (
  input  logic             video_clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             vs,
  output logic             at_origin,
  output logic             at_wrap
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(IMG_WIDTH + H_BLANK - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(IMG_HEIGHT + V_BLANK - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(IMG_WIDTH);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(IMG_HEIGHT);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(IMG_HEIGHT + VS_LINES);

  // A load parks the raster at the top of vertical blanking so the stream opens with vs.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (load) begin
      h_cnt <= '0;
      v_cnt <= V_ACT;
    end else if (run) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign vs        = (v_cnt >= V_ACT) && (v_cnt < VS_END);
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign at_wrap   = (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/video_stream_gen.sv
// rtl/video_stream_gen.sv - video timing and test-pattern source with run/stop FSM and frame counter
module video_stream_gen
  import video_stream_gen_pkg::*;
#(
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080,
  parameter int H_BLANK    = 280,
  parameter int V_BLANK    = 45,
  parameter int VS_LINES   = 5
) (
  input  logic       video_clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [2:0] pattern_sel,
  input  logic [7:0] fg_value,
  output logic       video_vs,
  output logic       video_de,
  output logic [7:0] video_data,
  output logic       frame_start,
  output logic [7:0] frame_cnt,
  output logic       busy
);

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(IMG_HEIGHT - 1);

  state_e           state, state_d;
  logic             load, run;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             active, vs, at_origin, at_wrap;
  logic             emit, last_px;
  logic [2:0]       pat_q, cur_pat;
  logic [7:0]       fg_q, cur_fg, pix;
  logic [7:0]       x, y;

  video_timing_core #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .H_BLANK   (H_BLANK),
    .V_BLANK   (V_BLANK),
    .VS_LINES  (VS_LINES)
  ) u_timing (
    .video_clk(video_clk),
    .rst_n    (rst_n),
    .load     (load),
    .run      (run),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .active   (active),
    .vs       (vs),
    .at_origin(at_origin),
    .at_wrap  (at_wrap)
  );

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    run     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        run = 1'b1;
        if (!enable) state_d = ST_STOP;
      end
      ST_STOP: begin
        // Only the final wrap ends the stream, so a stopped frame still completes with its blanking.
        if (enable) begin
          state_d = ST_RUN;
          run     = 1'b1;
        end else if (at_wrap) begin
          state_d = ST_IDLE;
        end else begin
          run = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign emit    = (state != ST_IDLE);
  assign last_px = (h_cnt == X_LAST) && (v_cnt == Y_LAST);
  assign x       = h_cnt[7:0];
  assign y       = v_cnt[7:0];

  // The origin pixel already belongs to the new frame, so it uses the live selection.
  assign cur_pat = at_origin ? pattern_sel : pat_q;
  assign cur_fg  = at_origin ? fg_value : fg_q;

  always_comb begin
    pix = 8'd0;
    case (cur_pat)
      PAT_HRAMP:   pix = x;
      PAT_VRAMP:   pix = y;
      PAT_CHECKER: pix = (x[3] ^ y[3]) ? cur_fg : 8'd0;
      PAT_CONST:   pix = cur_fg;
      PAT_MOVING:  pix = x + frame_cnt;
      PAT_DIAG:    pix = x + y;
      default:     pix = 8'd0;
    endcase
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      video_vs    <= 1'b0;
      video_de    <= 1'b0;
      video_data  <= 8'd0;
      frame_start <= 1'b0;
      frame_cnt   <= 8'd0;
      busy        <= 1'b0;
      pat_q       <= 3'd0;
      fg_q        <= 8'd0;
    end else begin
      video_vs    <= emit && vs;
      video_de    <= emit && active;
      video_data  <= (emit && active) ? pix : 8'd0;
      frame_start <= emit && at_origin;
      busy        <= (state_d != ST_IDLE);
      if (emit && at_origin) begin
        pat_q <= pattern_sel;
        fg_q  <= fg_value;
      end
      if (emit && last_px) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule
